writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
//   Y86-64 SEQ write-back stage plus architectural register file. It takes the
//   retiring instruction's icode, rA, rB, cnd, valE and valM, and derives the
//   destination registers dstE and dstM. On the rising clock it writes valE and
//   valM into the 15 program registers, which the decode stage reads back as
//   rax..r14. It also owns the processor status (AOK/HLT/INS) and a retired-
//   instruction counter.
// PARAMETERS
//   DATA_W   64  register and data width
//   CNT_W    32  width of the retired-instruction counter
//   RSP_INIT 0   reset value of rsp (reg 4); all other registers reset to 0
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous, active-low reset
//   instr_valid in   1       retiring instruction present this cycle
//   icode       in   4       instruction code
//   rA, rB      in   4 each  register specifiers; 4'hF means none
//   cnd         in   1       condition outcome from execute (cmovxx)
//   valE, valM  in   DATA_W  ALU result / memory read data
//   rax..r14    out  DATA_W  15 register contents, indices 0..14, registered
//   dstE, dstM  out  4       decoded destinations, combinational, 4'hF = none
//   stat        out  2       0=AOK 1=HLT 2=INS, registered
//   halted      out  1       stat != AOK
//   retired     out  CNT_W   count of committed instructions
// BEHAVIOUR
//   Reset (rst_n=0, async): all registers 0 except reg4=RSP_INIT; stat=AOK;
//     retired=0. dstE and dstM follow their inputs even while in reset.
//   dstE decode:
//     2 (cmovxx): rB if cnd, else F
//     3 (irmovq), 6 (OPq): rB
//     8, 9, A, B (call, ret, pushq, popq): 4
//     all other icodes: F
//   dstM decode: 5 (mrmovq) and B (popq): rA; all other icodes: F.
//   Commit: on posedge clk with instr_valid=1 and stat=AOK.
//     Write valE to dstE if dstE != F.
//     Write valM to dstM if dstM != F.
//     Latency: one cycle. The register outputs show new values after that edge.
//   Collision: if dstE == dstM (popq %rsp), valM wins.
//   Status on commit, per icode:
//     0 (halt): stat<=HLT, no register write, retired increments.
//     1 (nop), 7 (jXX): no write, retired increments.
//     C..F: stat<=INS, no write, retired does not increment.
//   Once stat != AOK, all writes and counting freeze until rst_n is asserted.
//   instr_valid=0: no state change.
//   retired wraps modulo 2^CNT_W.
//   Reset asserted mid-cycle overrides any pending write. The first commit is
//     the first posedge after rst_n deasserts.
//   rA=F on mrmovq or popq: dstM=F, so no M-write. The E-write (rsp) still
//     happens for popq.
// STRUCTURE
//   Shared package y86_pkg:
//     icode constants: IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ,
//       IJXX, ICALL, IRET, IPUSHQ, IPOPQ
//     RNONE=4'hF, RRSP=4'h4
//     stat_t enum: AOK, HLT, INS
//   Sub-module wb_dst_decode: combinational; (icode, rA, rB, cnd) -> dstE, dstM.
//   Top: 15-entry register array, status register, counter, output fan-out.
// TESTING
//   1. irmovq: icode=3, rB=2, valE=0x1234 -> rdx=0x1234 next cycle, retired=1.
//   2. cmovxx: icode=2, rB=3, valE=7.
//      cnd=0 -> dstE=F, rbx unchanged.
//      cnd=1 -> rbx=7.
//   3. popq %rsp: icode=B, rA=4, valE=0x108, valM=0xAA -> rsp=0xAA.
//      popq %rax with the same values -> rax=0xAA, rsp=0x108.
//   4. Halt: icode=0 -> stat=HLT, halted=1, retired+1. Then OPq valE=5, rB=1
//      -> rcx unchanged, retired frozen.
//   5. Invalid: icode=D -> stat=INS, no writes, retired unchanged.
//      Pulse rst_n low -> stat=AOK, rsp=RSP_INIT, all other registers 0.
//   6. instr_valid=0 with icode=3, rB=0 -> rax unchanged.
//      Preload retired=2^CNT_W-1 and commit a nop -> retired=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: icodes, register ids, status.
// Imported by the write-back stage and its decoder.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic [1:0] {
    AOK = 2'd0,
    HLT = 2'd1,
    INS = 2'd2
  } stat_t;

  function automatic logic is_bad_icode(
    input logic [3:0] ic
  );
    return ic > IPOPQ;
  endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// Retiring-instruction bundle handed to write-back.
// master drives it, slave (the regfile) consumes it.
interface writeback_regfile_if #(
  parameter int DATA_W = 64
);
  logic              instr_valid;
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              cnd;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;

  modport master (
    output instr_valid, icode, rA, rB,
    output cnd, valE, valM
  );

  modport slave (
    input instr_valid, icode, rA, rB,
    input cnd, valE, valM
  );
endinterface

// File: rtl/wb_dst_decode.sv
// Destination decode for write-back.
// Pure combinational; 4'hF means no write.
module wb_dst_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       cnd,
  output logic [3:0] dstE,
  output logic [3:0] dstM
);

  // E-port destination: rB for moves/ALU, rsp for stack ops
  always_comb begin
    dstE = RNONE;
    unique case (1'b1)
      (icode == IRRMOVQ):
        dstE = cnd ? rB : RNONE;
      (icode == IIRMOVQ),
      (icode == IOPQ):
        dstE = rB;
      (icode == ICALL),
      (icode == IRET),
      (icode == IPUSHQ),
      (icode == IPOPQ):
        dstE = RRSP;
      default:
        dstE = RNONE;
    endcase
  end

  // M-port destination: rA for loads and pops
  always_comb begin
    dstM = RNONE;
    unique case (1'b1)
      (icode == IMRMOVQ),
      (icode == IPOPQ):
        dstM = rA;
      default:
        dstM = RNONE;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back stage and program register file.
// Also holds processor status and retired count.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int               DATA_W   = 64,
  parameter int               CNT_W    = 32,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  writeback_regfile_if.slave  wb,
  output logic [DATA_W-1:0]   rax,
  output logic [DATA_W-1:0]   rcx,
  output logic [DATA_W-1:0]   rdx,
  output logic [DATA_W-1:0]   rbx,
  output logic [DATA_W-1:0]   rsp,
  output logic [DATA_W-1:0]   rbp,
  output logic [DATA_W-1:0]   rsi,
  output logic [DATA_W-1:0]   rdi,
  output logic [DATA_W-1:0]   r8,
  output logic [DATA_W-1:0]   r9,
  output logic [DATA_W-1:0]   r10,
  output logic [DATA_W-1:0]   r11,
  output logic [DATA_W-1:0]   r12,
  output logic [DATA_W-1:0]   r13,
  output logic [DATA_W-1:0]   r14,
  output logic [3:0]          dstE,
  output logic [3:0]          dstM,
  output logic [1:0]          stat,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  logic [DATA_W-1:0] regs [15];
  stat_t             stat_q;
  logic              commit;

  wb_dst_decode u_dec (
    .icode (wb.icode),
    .rA    (wb.rA),
    .rB    (wb.rB),
    .cnd   (wb.cnd),
    .dstE  (dstE),
    .dstM  (dstM)
  );

  assign commit = wb.instr_valid && (stat_q == AOK);

  // Register writes; M-port written last so it wins on dstE==dstM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++)
        regs[i] <= (i == 4) ? RSP_INIT : '0;
    end else if (commit) begin
      if (dstE != RNONE)
        regs[dstE] <= wb.valE;
      if (dstM != RNONE)
        regs[dstM] <= wb.valM;
    end
  end

  // Status: halt or bad icode stops the machine until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stat_q <= AOK;
    else if (commit) begin
      if (is_bad_icode(wb.icode))
        stat_q <= INS;
      else if (wb.icode == IHALT)
        stat_q <= HLT;
    end
  end

  // Retired counter; bad icodes do not retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired <= '0;
    else if (commit && !is_bad_icode(wb.icode))
      retired <= retired + CNT_W'(1);
  end

  assign stat   = stat_q;
  assign halted = (stat_q != AOK);

  assign rax = regs[0];
  assign rcx = regs[1];
  assign rdx = regs[2];
  assign rbx = regs[3];
  assign rsp = regs[4];
  assign rbp = regs[5];
  assign rsi = regs[6];
  assign rdi = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile.
// Small counter width to reach wrap quickly.
module tb_writeback_regfile;

  localparam int          DW   = 64;
  localparam int          CW   = 4;
  localparam logic [63:0] RSPI = 64'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [DW-1:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
  logic [DW-1:0] r8, r9, r10, r11, r12, r13, r14;
  logic [3:0]    dstE, dstM;
  logic [1:0]    stat;
  logic          halted;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;

  writeback_regfile_if #(.DATA_W(DW)) wbi ();

  writeback_regfile #(
    .DATA_W   (DW),
    .CNT_W    (CW),
    .RSP_INIT (RSPI)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb      (wbi),
    .rax     (rax),
    .rcx     (rcx),
    .rdx     (rdx),
    .rbx     (rbx),
    .rsp     (rsp),
    .rbp     (rbp),
    .rsi     (rsi),
    .rdi     (rdi),
    .r8      (r8),
    .r9      (r9),
    .r10     (r10),
    .r11     (r11),
    .r12     (r12),
    .r13     (r13),
    .r14     (r14),
    .dstE    (dstE),
    .dstM    (dstM),
    .stat    (stat),
    .halted  (halted),
    .retired (retired)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic        v,
    input logic [3:0]  ic,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic        c,
    input logic [63:0] e,
    input logic [63:0] m
  );
    @(negedge clk);
    wbi.instr_valid = v;
    wbi.icode = ic;
    wbi.rA = ra;
    wbi.rB = rb;
    wbi.cnd = c;
    wbi.valE = e;
    wbi.valM = m;
  endtask

  task automatic edge_done();
    @(posedge clk);
    #1;
    wbi.instr_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    wbi.instr_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    wbi.instr_valid = 1'b0;
    wbi.icode = 4'h3;
    wbi.rA = 4'hF;
    wbi.rB = 4'h2;
    wbi.cnd = 1'b0;
    wbi.valE = '0;
    wbi.valM = '0;
    #12;
    chk("rst_rsp", rsp, RSPI);
    chk("rst_rax", rax, 0);
    chk("rst_r14", r14, 0);
    chk("rst_stat", stat, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_dstE_follow", dstE, 4'h2);
    chk("rst_dstM_follow", dstM, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // irmovq -> rdx
    drive(1, 4'h3, 4'hF, 4'h2, 0, 64'h1234, 0);
    edge_done();
    chk("irmovq_rdx", rdx, 64'h1234);
    chk("irmovq_ret", retired, 1);

    // cmov not taken
    drive(1, 4'h2, 4'h0, 4'h3, 0, 64'h7, 0);
    #1;
    chk("cmov0_dstE", dstE, 4'hF);
    edge_done();
    chk("cmov0_rbx", rbx, 0);
    chk("cmov0_ret", retired, 2);

    // cmov taken
    drive(1, 4'h2, 4'h0, 4'h3, 1, 64'h7, 0);
    edge_done();
    chk("cmov1_rbx", rbx, 7);

    // popq %rsp: valM wins
    drive(1, 4'hB, 4'h4, 4'hF, 0, 64'h108, 64'hAA);
    #1;
    chk("pop4_dstE", dstE, 4'h4);
    chk("pop4_dstM", dstM, 4'h4);
    edge_done();
    chk("pop4_rsp", rsp, 64'hAA);

    // popq %rax
    drive(1, 4'hB, 4'h0, 4'hF, 0, 64'h108, 64'hAA);
    edge_done();
    chk("pop0_rax", rax, 64'hAA);
    chk("pop0_rsp", rsp, 64'h108);
    chk("pop0_ret", retired, 5);

    // instr_valid low: nothing changes
    drive(0, 4'h3, 4'hF, 4'h0, 0, 64'h55, 0);
    edge_done();
    chk("nv_rax", rax, 64'hAA);
    chk("nv_ret", retired, 5);

    // popq with rA=F: only the rsp update
    drive(1, 4'hB, 4'hF, 4'hF, 0, 64'h200, 64'h77);
    #1;
    chk("popF_dstM", dstM, 4'hF);
    edge_done();
    chk("popF_rsp", rsp, 64'h200);
    chk("popF_rax", rax, 64'hAA);

    // mrmovq -> rsi
    drive(1, 4'h5, 4'h6, 4'h1, 0, 64'h11, 64'h99);
    #1;
    chk("mrm_dstE", dstE, 4'hF);
    edge_done();
    chk("mrm_rsi", rsi, 64'h99);
    chk("mrm_rcx", rcx, 0);
    chk("mrm_ret", retired, 7);

    // nops up to the counter wrap
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'h1, 4'hF, 4'hF, 0, 0, 0);
      edge_done();
    end
    chk("nop_ret_max", retired, 15);
    drive(1, 4'h1, 4'hF, 4'hF, 0, 0, 0);
    edge_done();
    chk("nop_ret_wrap", retired, 0);

    // halt, then a frozen OPq
    drive(1, 4'h0, 4'hF, 4'hF, 0, 0, 0);
    edge_done();
    chk("halt_stat", stat, 1);
    chk("halt_halted", halted, 1);
    chk("halt_ret", retired, 1);
    drive(1, 4'h6, 4'hF, 4'h1, 0, 64'h5, 0);
    edge_done();
    chk("frz_rcx", rcx, 0);
    chk("frz_ret", retired, 1);

    // reset pulse restores defaults
    pulse_reset();
    #1;
    chk("rp_stat", stat, 0);
    chk("rp_rsp", rsp, RSPI);
    chk("rp_rax", rax, 0);
    chk("rp_rdx", rdx, 0);
    chk("rp_rsi", rsi, 0);
    chk("rp_ret", retired, 0);

    // invalid icode
    drive(1, 4'hD, 4'h0, 4'h0, 0, 64'h3, 64'h4);
    edge_done();
    chk("ins_stat", stat, 2);
    chk("ins_halted", halted, 1);
    chk("ins_ret", retired, 0);
    chk("ins_rax", rax, 0);
    drive(1, 4'h3, 4'hF, 4'h2, 0, 64'h9, 0);
    edge_done();
    chk("ins_frz_rdx", rdx, 0);

    // reset landing on a pending write wins
    pulse_reset();
    @(negedge clk);
    wbi.instr_valid = 1'b1;
    wbi.icode = 4'h3;
    wbi.rB = 4'h2;
    wbi.valE = 64'hBEEF;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_rdx", rdx, 0);
    chk("mid_rst_ret", retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wbi.rB = 4'h7;
    wbi.valE = 64'h77;
    @(posedge clk);
    #1;
    wbi.instr_valid = 1'b0;
    chk("first_rdi", rdi, 64'h77);
    chk("first_ret", retired, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
